// File: rtl/mul_acc_pkg.sv
// Shared types and default widths for the mul_64 downstream accumulator.
package mul_acc_pkg;

  // Product width matches the mul_64 result; guard bits absorb carries of long jobs.
  localparam int DEF_PROD_W  = 128;
  localparam int DEF_GUARD_W = 8;
  localparam int DEF_LEN_W   = 16;
  localparam int DEF_ACC_W   = DEF_PROD_W + DEF_GUARD_W;

  // Job sequencing: waiting for start, summing beats, presenting the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/acc_add.sv
// W-bit Kogge-Stone adder with carry out, carry-in fixed at zero.
// Built in the same prefix style as ksa64x64 so both adders share structure.
module acc_add
  import mul_acc_pkg::*;
#(
  parameter int W = DEF_ACC_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  // Level l holds group generate/propagate spanning 2^l bits ending at each position.
  localparam int LVL = $clog2(W);

  logic [W-1:0] gAll;

  genvar l;
  for (l = 0; l < LVL; l++) begin : g_lvl
    logic [W-1:0] g;
    logic [W-1:0] p;
    if (l == 0) begin : g_base
      // Bitwise generate and propagate seed the prefix tree.
      assign g = a_i & b_i;
      assign p = a_i ^ b_i;
    end else begin : g_pre
      // Combine each group with the neighbour 2^(l-1) bits below; zeros shift in at the bottom.
      assign g = g_lvl[l-1].g | (g_lvl[l-1].p & (g_lvl[l-1].g << (1 << (l-1))));
      assign p = g_lvl[l-1].p & (g_lvl[l-1].p << (1 << (l-1)));
    end
  end

  // The last combine stretches every group down to bit 0, giving the carry out of each bit.
  assign gAll   = g_lvl[LVL-1].g | (g_lvl[LVL-1].p & (g_lvl[LVL-1].g << (1 << (LVL-1))));
  assign sum_o  = g_lvl[0].p ^ {gAll[W-2:0], 1'b0};
  assign cout_o = gAll[W-1];

endmodule

// File: rtl/mul_acc_64.sv
// Streaming dot-product accumulator placed after mul_64: sums a programmed number
// of 128-bit products into a guarded accumulator and hands the sum out by valid/ready.
module mul_acc_64
  import mul_acc_pkg::*;
#(
  parameter int PROD_W  = DEF_PROD_W,
  parameter int GUARD_W = DEF_GUARD_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LEN_W-1:0]            len,
  input  logic                        abort,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PROD_W-1:0]           prod,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PROD_W+GUARD_W-1:0]   acc_out,
  output logic                        overflow,
  output logic                        busy
);

  localparam int ACC_W = PROD_W + GUARD_W;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   accSum_d;
  logic               carry_d;
  logic [LEN_W-1:0]   count_q;
  logic [LEN_W-1:0]   count_d;
  logic [LEN_W-1:0]   len_q;
  logic               lastBeat_d;
  logic               beatTake_d;
  logic               inReady_q;
  logic               outValid_q;
  logic               overflow_q;
  logic               busy_q;

  // Product is unsigned, so it is zero-extended into the guard bits.
  acc_add #(
    .W (ACC_W)
  ) u_accAdd (
    .a_i    (acc_q),
    .b_i    ({{GUARD_W{1'b0}}, prod}),
    .sum_o  (accSum_d),
    .cout_o (carry_d)
  );

  assign count_d    = count_q + LEN_W'(1);
  assign lastBeat_d = (count_d == len_q);
  assign beatTake_d = in_valid && inReady_q;

  // Single FSM register block; handshake flags are registered alongside the state
  // so no input ever reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      len_q      <= '0;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (abort) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            if (len != '0) begin
              len_q     <= len;
              state_q   <= ACCUM;
              inReady_q <= 1'b1;
            end else begin
              state_q    <= DONE;
              outValid_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (beatTake_d) begin
            acc_q      <= accSum_d;
            count_q    <= count_d;
            overflow_q <= overflow_q | carry_d;
            if (lastBeat_d) begin
              state_q    <= DONE;
              inReady_q  <= 1'b0;
              outValid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          inReady_q  <= 1'b0;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign acc_out   = acc_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul_acc_64.sv
// Directed bench for mul_acc_64: expected sums are pushed when a job is launched
// and popped when the accumulator presents its result.
module tb_mul_acc_64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [15:0]    len;
  logic           abort;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   prod;
  logic           out_valid;
  logic           out_ready;
  logic [135:0]   acc_out;
  logic           overflow;
  logic           busy;

  typedef struct packed {
    logic [135:0] sum;
    logic         ovf;
  } exp_t;

  exp_t         expQ[$];
  logic [127:0] beatQ[$];
  int           checkCount = 0;
  int           passCount  = 0;
  int           failCount  = 0;

  mul_acc_64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case a handshake never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete (passed %0d of %0d)", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a job of n beats taken from beatQ, record its expected sum, stream beats back to back.
  task automatic applyStimulus(input int n);
    logic [143:0] model;
    exp_t         e;
    model = '0;
    for (int i = 0; i < n; i++) model = model + {16'b0, beatQ[i]};
    e.sum = model[135:0];
    e.ovf = |model[143:136];
    expQ.push_back(e);
    start = 1'b1;
    len   = 16'(n);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      prod     = beatQ[i];
      tick();
    end
    in_valid = 1'b0;
    prod     = '0;
    beatQ.delete();
  endtask

  // Wait a bounded time for the result, compare with the scoreboard, then complete the handshake.
  task automatic waitOutput(input string tag);
    int   cycles;
    exp_t e;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 50) begin
      tick();
      cycles++;
    end
    checkOutput({tag, " out_valid"}, out_valid, 1);
    checkOutput({tag, " pending"}, expQ.size(), 1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({tag, " acc_out"}, acc_out, e.sum);
      checkOutput({tag, " overflow"}, overflow, e.ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after handshake"}, out_valid, 0);
    checkOutput({tag, " busy after handshake"}, busy, 0);
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    prod      = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset acc_out", acc_out, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a 4-beat job
    start = 1'b1;
    len   = 16'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    prod     = 128'd3;
    tick();
    prod = 128'd4;
    tick();
    in_valid = 1'b0;
    checkOutput("midjob acc_out", acc_out, 7);
    checkOutput("midjob busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset acc_out", acc_out, 0);
    checkOutput("midreset in_ready", in_ready, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset out_valid", out_valid, 0);
    rst_n = 1'b1;
    tick();

    // Basic dot product 5+7+11
    beatQ.push_back(128'd5);
    beatQ.push_back(128'd7);
    beatQ.push_back(128'd11);
    applyStimulus(3);
    checkOutput("basic latency out_valid", out_valid, 1);
    checkOutput("basic in_ready dropped", in_ready, 0);
    waitOutput("basic");

    // Back-pressure on both sides: 9 + 20 with a gap, then a stalled consumer
    e.sum = 136'd29;
    e.ovf = 1'b0;
    expQ.push_back(e);
    start = 1'b1;
    len   = 16'd2;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    prod     = 128'd9;
    tick();
    in_valid = 1'b0;
    prod     = 128'd55;
    tick();
    checkOutput("bp gap in_ready", in_ready, 1);
    checkOutput("bp gap acc_out", acc_out, 9);
    in_valid = 1'b1;
    prod     = 128'd20;
    tick();
    prod = 128'd100;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp stall acc_out", acc_out, 29);
      checkOutput("bp stall out_valid", out_valid, 1);
      tick();
    end
    in_valid = 1'b0;
    prod     = '0;
    waitOutput("backpressure");

    // Zero-length job, then a start that arrives while DONE
    applyStimulus(0);
    checkOutput("zero out_valid", out_valid, 1);
    start = 1'b1;
    len   = 16'd5;
    tick();
    start = 1'b0;
    checkOutput("ignored start busy", busy, 1);
    checkOutput("ignored start in_ready", in_ready, 0);
    waitOutput("zero");
    tick();
    checkOutput("ignored start not latched", in_ready, 0);

    // Overflow: 257 all-ones products wrap past the 8 guard bits
    for (int i = 0; i < 257; i++) beatQ.push_back({128{1'b1}});
    applyStimulus(257);
    checkOutput("overflow flag", overflow, 1);
    waitOutput("overflow");

    // Abort arriving together with the final beat
    start = 1'b1;
    len   = 16'd3;
    tick();
    start = 1'b0;
    checkOutput("start clears overflow", overflow, 0);
    in_valid = 1'b1;
    prod     = 128'd1;
    tick();
    prod = 128'd2;
    tick();
    prod  = 128'd4;
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    prod     = '0;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort in_ready", in_ready, 0);
    checkOutput("abort acc_out", acc_out, 0);
    checkOutput("abort overflow", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("abort out_valid", out_valid, 0);
      tick();
    end

    // Normal job after abort
    beatQ.push_back(128'd42);
    applyStimulus(1);
    waitOutput("recover");

    checkOutput("scoreboard empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mul_acc_64.md
Name: mul_acc_64

Overview:
Dot-product accumulator stage placed directly downstream of the 64x64 Vedic multiplier (mul_64).
- Consumes the multiplier's 128-bit unsigned products through a valid/ready handshake.
- Sums a programmed number of products into a guarded accumulator.
- Presents the final sum through an output valid/ready handshake.
- Turns the purely combinational multiplier into a streaming MAC datapath usable by a sequencer.

Parameters:
PROD_W, 128, width of incoming product (matches mul_64 result width)
GUARD_W, 8, guard bits above PROD_W; ACC_W = PROD_W + GUARD_W
LEN_W, 16, width of the programmed product count

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a new accumulation (honoured only in IDLE)
len  input  LEN_W  number of products to accumulate; sampled when start is accepted
abort  input  1  pulse; cancels the current job from any state
in_valid  input  1  product beat valid
in_ready  output  1  accumulator accepts product this cycle
prod  input  PROD_W  unsigned product from mul_64
out_valid  output  1  acc_out holds the final sum
out_ready  input  1  consumer accepts acc_out
acc_out  output  ACC_W  accumulated sum
overflow  output  1  sticky; carry out of ACC_W occurred during the current job
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (async assert, sync-to-clk deassert handled externally):
  - state=IDLE; acc=0, count=0, len_q=0.
  - Outputs: in_ready=0, out_valid=0, acc_out=0, overflow=0, busy=0.
- States: IDLE, ACCUM, DONE. Registered state; all outputs are decoded from registers, with no combinational path from an input to an output.
- IDLE:
  - start=1 and len!=0: len_q<=len, acc<=0, count<=0, overflow<=0, next ACCUM.
  - start=1 and len==0: acc<=0, overflow<=0, next DONE, so a zero-length job returns 0.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready: acc<=acc+{GUARD_W'b0,prod} (ACC_W-bit add), count<=count+1.
  - The carry out of bit ACC_W-1 sets overflow (sticky); acc wraps modulo 2^ACC_W.
  - When the accepted beat makes count+1==len_q, next state is DONE and in_ready drops the following cycle. Exactly len_q beats are consumed.
  - in_valid low: no change, no timeout.
- DONE:
  - out_valid=1; acc_out=acc, held stable until the handshake.
  - out_valid&&out_ready returns to IDLE next cycle. acc_out keeps its value in IDLE until the next start; out_valid=0.
- Latency: the final sum is visible one cycle after the last accepted beat. Throughput is 1 product/cycle.
- abort=1 in any state: next IDLE, acc<=0, count<=0, overflow<=0. abort has priority over start, beat acceptance and the output handshake in the same cycle.
- start outside IDLE is ignored. Changes to len outside the start cycle are ignored.
- prod is unsigned; no sign extension.

Decomposition:
- Shared package mul_acc_pkg: state enum {IDLE, ACCUM, DONE}; default widths PROD_W=128, GUARD_W=8, LEN_W=16; localparam ACC_W.
- One sub-module: acc_add, an ACC_W-bit adder with carry out. Combinational; Kogge-Stone style to match ksa64x64, so it can later replace a behavioural '+'.
- The FSM, counter and handshake stay in mul_acc_64.

Test Plan:
- Reset mid-job: after 2 of 4 beats assert rst_n=0 -> all outputs 0 immediately, state IDLE after release, next start behaves normally.
- Basic dot product: start, len=3; prods 5, 7, 11 with in_valid continuous -> out_valid one cycle after third beat, acc_out=23, overflow=0, in_ready low after third beat.
- Back-pressure both sides: len=2, in_valid toggled 1,0,1; out_ready held 0 for 3 cycles -> acc_out stable across stall, exactly 2 beats consumed, return to IDLE one cycle after out_ready=1.
- Zero length and ignored start: start with len=0 -> DONE with acc_out=0. A second start asserted while in DONE has no effect.
- Overflow wrap: GUARD_W=8; accumulate 257 beats of prod=2^128-1 -> overflow=1. acc_out equals (257*(2^128-1)) mod 2^136.
- Abort priority: in ACCUM, assert abort together with in_valid and a final beat -> beat not counted, IDLE next cycle, acc=0, out_valid never asserted.
